ps2_kbd_rx: RTL and testbench

- Memory-mapped PS/2 keyboard receiver. It sits between the board PS/2 pins and the CPU data bus inside memory_top.
- Deserialises 11-bit device-to-host frames, checks them, and buffers scan codes in a FIFO.
- The CPU reads the buffered codes through the same single-cycle request/acknowledge bus used by the other peripherals.

---
 rtl/ps2_kbd_pkg.sv | 15 +
 rtl/sync_fifo.sv | 43 ++++
 rtl/ps2_kbd_rx.sv | 179 +++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg: shared constants and types for the PS/2 keyboard receiver.
// Holds the register offsets, the STATUS bit positions, the frame FSM state
// encoding and the PS/2 frame length.
package ps2_kbd_pkg;
    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CONTROL = 2'd2;
    localparam int ST_NEMPTY = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_PERR   = 3;
    localparam int ST_FERR   = 4;
    localparam int FRAME_BITS = 11;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with push/pop/flush, reusable by any peripheral.
// Ports: clk, rst_n (async active-low), push/din write side, pop/dout read side
// (dout shows the head entry), flush empties the FIFO, full/empty/count status.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: memory-mapped PS/2 keyboard receiver with a scan-code FIFO.
// Ports: i_clk/i_rst_n (async active-low) system clock and reset;
// i_ps2_clk/i_ps2_data raw PS/2 pins; i_cs, i_bus_DV, i_bus_address,
// i_bus_data, i_bhw, i_write_notread bus request; o_bus_data/o_bus_DV
// registered one-cycle acknowledge.
// Optional macro PS2_KBD_IRQ_EN adds o_irq and the CONTROL[1] IRQ enable.
module ps2_kbd_rx
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ps2_clk,
    input  logic        i_ps2_data,
    input  logic        i_cs,
    input  logic        i_bus_DV,
    input  logic [31:0] i_bus_address,
    input  logic [31:0] i_bus_data,
    input  logic [2:0]  i_bhw,
    input  logic        i_write_notread,
    output logic [31:0] o_bus_data,
    output logic        o_bus_DV
`ifdef PS2_KBD_IRQ_EN
    ,
    output logic        o_irq
`endif
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic clk_prev, fall, bit_in;
    frame_state_t state, state_n;
    logic [7:0] shreg, sh_n;
    logic [2:0] bit_cnt, cnt_n;
    logic par, par_n;
    logic [TW-1:0] tmo_cnt, tmo_n;
    logic push, perr_set, ferr_set, ovf_set;
    logic accept, rd, wr, pop, flush;
    logic [1:0] addr;
    logic [2:0] flags, clr;
    logic [7:0] dout;
    logic full, empty;
    logic [AW:0] count;
    logic [31:0] status, rdata;
    logic irq_en;
    logic unused;

    assign unused = ^{i_bhw, i_bus_address[31:4], i_bus_address[1:0], i_bus_data[31:5], i_bus_data[1]};

    // Synchronisers preset high so reset looks like an idle bus, not an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], i_ps2_data};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end
    assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign bit_in = dat_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            par     <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_n;
            shreg   <= sh_n;
            bit_cnt <= cnt_n;
            par     <= par_n;
            tmo_cnt <= tmo_n;
        end
    end

    always_comb begin
        state_n  = state;
        sh_n     = shreg;
        cnt_n    = bit_cnt;
        par_n    = par;
        push     = 1'b0;
        perr_set = 1'b0;
        ferr_set = 1'b0;
        tmo_n    = (state == IDLE || fall) ? '0 : tmo_cnt + 1'b1;
        if (state != IDLE && tmo_cnt == TW'(TIMEOUT_CYCLES)) begin
            state_n  = IDLE;
            ferr_set = 1'b1;
            tmo_n    = '0;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    state_n = bit_in ? IDLE : DATA;
                    cnt_n   = '0;
                end
                DATA: begin
                    sh_n    = {bit_in, shreg[7:1]};
                    cnt_n   = bit_cnt + 1'b1;
                    state_n = (bit_cnt == 3'(FRAME_BITS - 4)) ? PARITY : DATA;
                end
                PARITY: begin
                    par_n   = bit_in;
                    state_n = STOP;
                end
                STOP: begin
                    state_n  = IDLE;
                    push     = bit_in & ^{shreg, par};
                    perr_set = ~^{shreg, par};
                    ferr_set = ~bit_in;
                end
            endcase
        end
    end

    assign accept = i_cs & i_bus_DV;
    assign rd     = accept & ~i_write_notread;
    assign wr     = accept & i_write_notread;
    assign addr   = i_bus_address[3:2];
    assign pop    = rd & (addr == REG_DATA);
    assign flush  = wr & (addr == REG_CONTROL) & i_bus_data[0];
    assign clr    = (wr && addr == REG_STATUS) ? i_bus_data[4:2] : 3'b0;
    assign ovf_set = push & full & ~(pop & ~empty);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (shreg),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // flags = {FERR, PERR, OVF}; a set in the same cycle as its clear wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) flags <= '0;
        else flags <= (flags & ~clr) | {ferr_set, perr_set, ovf_set};
    end

`ifdef PS2_KBD_IRQ_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            irq_en <= 1'b0;
            o_irq  <= 1'b0;
        end else begin
            if (wr && addr == REG_CONTROL) irq_en <= i_bus_data[1];
            o_irq <= irq_en & (~empty | flags[0]);
        end
    end
`else
    assign irq_en = 1'b0;
`endif

    assign status = {16'b0, 8'(count), 3'b0, flags, full, ~empty};
    assign rdata  = (addr == REG_DATA)    ? (empty ? 32'b0 : {23'b0, 1'b1, dout}) :
                    (addr == REG_STATUS)  ? status :
                    (addr == REG_CONTROL) ? {30'b0, irq_en, 1'b0} : 32'b0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_bus_DV   <= 1'b0;
            o_bus_data <= '0;
        end else begin
            o_bus_DV   <= accept;
            o_bus_data <= rd ? rdata : 32'b0;
        end
    end
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: directed self-checking bench for ps2_kbd_rx.
module tb_ps2_kbd_rx;
    localparam int HALF = 4;
    localparam logic [1:0] A_DATA = 2'd0, A_STAT = 2'd1, A_CTRL = 2'd2, A_RSV = 2'd3;
`ifdef PS2_KBD_IRQ_EN
    localparam logic [31:0] CTRL_IRQ_RD = 32'h2;
`else
    localparam logic [31:0] CTRL_IRQ_RD = 32'h0;
`endif

    logic clk = 0, rst_n = 0, ps2_clk = 1, ps2_data = 1;
    logic cs = 0, dv = 0, we = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic [2:0] bhw = 0;
    logic [31:0] rdata;
    logic ack;
`ifdef PS2_KBD_IRQ_EN
    logic irq;
`endif
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    ps2_kbd_rx dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_ps2_clk       (ps2_clk),
        .i_ps2_data      (ps2_data),
        .i_cs            (cs),
        .i_bus_DV        (dv),
        .i_bus_address   (addr),
        .i_bus_data      (wdata),
        .i_bhw           (bhw),
        .i_write_notread (we),
        .o_bus_data      (rdata),
        .o_bus_DV        (ack)
`ifdef PS2_KBD_IRQ_EN
        ,
        .o_irq           (irq)
`endif
    );

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d, output logic k);
        @(negedge clk);
        cs = 1; dv = 1; we = 0; addr = {28'b0, a, 2'b0};
        @(negedge clk);
        k = ack; d = rdata;
        cs = 0; dv = 0;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] v, output logic k);
        @(negedge clk);
        cs = 1; dv = 1; we = 1; addr = {28'b0, a, 2'b0}; wdata = v;
        @(negedge clk);
        k = ack;
        cs = 0; dv = 0; we = 0;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            cycles(HALF);
            ps2_clk = 0;
            cycles(HALF);
            ps2_clk = 1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
        send_bits({s, p, b, 1'b0}, 11);
        ps2_data = 1;
        cycles(2 * HALF);
    endtask

    task automatic good(input logic [7:0] b);
        send_frame(b, ~^b, 1'b1);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic k;
        cycles(3);
        checks++;
        if (ack !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got ack=%b data=%h want ack=0 data=0", ack, rdata);
        end
        @(negedge clk) rst_n = 1;
        bus_rd(A_STAT, d, k);
        checks++;
        if (k !== 1'b1 || d !== 32'h0) begin
            errors++;
            $display("FAIL reset_status got ack=%b data=%h want ack=1 data=0", k, d);
        end
        bus_rd(A_DATA, d, k);
        checks++;
        if (k !== 1'b1 || d !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got ack=%b data=%h want ack=1 data=0", k, d);
        end
    endtask

    task automatic test_single;
        logic [31:0] d;
        logic k;
        good(8'h1C);
        bus_rd(A_STAT, d, k);
        checks++;
        if (d !== 32'h101) begin errors++; $display("FAIL single_status got %h want 00000101", d); end
        bus_rd(A_DATA, d, k);
        checks++;
        if (d !== 32'h11C) begin errors++; $display("FAIL single_data got %h want 0000011c", d); end
        bus_rd(A_DATA, d, k);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL single_empty got %h want 0", d); end
    endtask

    task automatic test_errors;
        logic [7:0]  tb [3] = '{8'hF0, 8'h1C, 8'hF0};
        logic        tp [3] = '{1'b0, 1'b0, 1'b0};
        logic        ts [3] = '{1'b1, 1'b0, 1'b0};
        logic [31:0] te [3] = '{32'h08, 32'h10, 32'h18};
        logic [31:0] d;
        logic k;
        for (int i = 0; i < 3; i++) begin
            send_frame(tb[i], tp[i], ts[i]);
            bus_rd(A_STAT, d, k);
            checks++;
            if (d !== te[i]) begin errors++; $display("FAIL err_flags[%0d] got %h want %h", i, d, te[i]); end
            bus_wr(A_STAT, te[i], k);
            bus_rd(A_STAT, d, k);
            checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL err_clear[%0d] got %h want 0", i, d); end
        end
        send_frame(8'hF0, 1'b1, 1'b1);
        bus_rd(A_DATA, d, k);
        checks++;
        if (d !== 32'h1F0) begin errors++; $display("FAIL parity_ok got %h want 000001f0", d); end
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        logic k;
        for (int i = 1; i <= 17; i++) good(8'(i));
        bus_rd(A_STAT, d, k);
        checks++;
        if (d !== 32'h1007) begin errors++; $display("FAIL ovf_status got %h want 00001007", d); end
        for (int i = 1; i <= 16; i++) begin
            bus_rd(A_DATA, d, k);
            checks++;
            if (d !== (32'h100 | i)) begin errors++; $display("FAIL ovf_order[%0d] got %h want %h", i, d, 32'h100 | i); end
        end
        bus_rd(A_STAT, d, k);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL ovf_drained got %h want 00000004", d); end
        bus_wr(A_STAT, 32'h4, k);
        bus_rd(A_STAT, d, k);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL ovf_clear got %h want 0", d); end
    endtask

    task automatic test_timeout;
        logic [31:0] d;
        logic k;
        send_bits(11'b000_0010_1100, 6);
        cycles(49700);
        bus_rd(A_STAT, d, k);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL tmo_early got %h want 0", d); end
        cycles(500);
        bus_rd(A_STAT, d, k);
        checks++;
        if (d !== 32'h10) begin errors++; $display("FAIL tmo_ferr got %h want 00000010", d); end
        bus_wr(A_STAT, 32'h10, k);
        good(8'h29);
        bus_rd(A_DATA, d, k);
        checks++;
        if (d !== 32'h129) begin errors++; $display("FAIL tmo_recover got %h want 00000129", d); end
    endtask

    task automatic test_simul;
        logic [31:0] d;
        logic k;
        good(8'h11);
        send_bits({1'b1, 1'b1, 8'h22, 1'b0}, 10);
        @(negedge clk);
        ps2_data = 1;
        cycles(HALF);
        ps2_clk = 0;
        cycles(2);
        cs = 1; dv = 1; we = 0; addr = 32'h0;
        @(negedge clk);
        k = ack; d = rdata;
        cs = 0; dv = 0;
        cycles(HALF);
        ps2_clk = 1;
        cycles(HALF);
        checks++;
        if (k !== 1'b1 || d !== 32'h111) begin
            errors++;
            $display("FAIL simul_head got ack=%b data=%h want ack=1 data=00000111", k, d);
        end
        bus_rd(A_STAT, d, k);
        checks++;
        if (d !== 32'h101) begin errors++; $display("FAIL simul_count got %h want 00000101", d); end
        bus_rd(A_DATA, d, k);
        checks++;
        if (d !== 32'h122) begin errors++; $display("FAIL simul_new got %h want 00000122", d); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        logic k;
        good(8'h5A);
        good(8'h3C);
        @(negedge clk);
        cs = 1; dv = 1; we = 0; addr = 32'h0;
        @(negedge clk);
        checks++;
        if (ack !== 1'b1 || rdata !== 32'h15A) begin
            errors++;
            $display("FAIL b2b_first got ack=%b data=%h want ack=1 data=0000015a", ack, rdata);
        end
        @(negedge clk);
        checks++;
        if (ack !== 1'b1 || rdata !== 32'h13C) begin
            errors++;
            $display("FAIL b2b_second got ack=%b data=%h want ack=1 data=0000013c", ack, rdata);
        end
        cs = 0; dv = 0;
        @(negedge clk);
        checks++;
        if (ack !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL b2b_idle got ack=%b data=%h want ack=0 data=0", ack, rdata);
        end
        good(8'h77);
        @(negedge clk);
        cs = 0; dv = 1; we = 0; addr = 32'h0;
        @(negedge clk);
        dv = 0;
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL no_cs got ack=%b want 0", ack); end
        bus_wr(A_DATA, 32'hFF, k);
        checks++;
        if (k !== 1'b1) begin errors++; $display("FAIL data_wr_ack got %b want 1", k); end
        bus_rd(A_STAT, d, k);
        checks++;
        if (d !== 32'h101) begin errors++; $display("FAIL no_cs_status got %h want 00000101", d); end
        bus_rd(A_DATA, d, k);
        checks++;
        if (d !== 32'h177) begin errors++; $display("FAIL no_cs_data got %h want 00000177", d); end
    endtask

    task automatic test_flush;
        logic [31:0] d;
        logic k;
        good(8'h12);
        good(8'h34);
        bus_rd(A_STAT, d, k);
        checks++;
        if (d !== 32'h201) begin errors++; $display("FAIL flush_pre got %h want 00000201", d); end
        bus_wr(A_CTRL, 32'h1, k);
        bus_rd(A_STAT, d, k);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL flush_status got %h want 0", d); end
        bus_rd(A_CTRL, d, k);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL flush_selfclr got %h want 0", d); end
        bus_wr(A_CTRL, 32'h2, k);
        bus_rd(A_CTRL, d, k);
        checks++;
        if (d !== CTRL_IRQ_RD) begin errors++; $display("FAIL ctrl_irq got %h want %h", d, CTRL_IRQ_RD); end
        bus_wr(A_CTRL, 32'h0, k);
        bus_wr(A_RSV, 32'hFFFF_FFFF, k);
        bus_rd(A_RSV, d, k);
        checks++;
        if (k !== 1'b1 || d !== 32'h0) begin
            errors++;
            $display("FAIL rsv_read got ack=%b data=%h want ack=1 data=0", k, d);
        end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] d;
        logic k;
        good(8'h01);
        good(8'h02);
        good(8'h03);
        send_bits({1'b1, 1'b0, 8'h45, 1'b0}, 5);
        @(negedge clk);
        cs = 1; dv = 1; we = 0; addr = {28'b0, A_STAT, 2'b0};
        rst_n = 0;
        cycles(2);
        cs = 0; dv = 0;
        checks++;
        if (ack !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL midrst_outputs got ack=%b data=%h want ack=0 data=0", ack, rdata);
        end
        @(negedge clk) rst_n = 1;
        bus_rd(A_STAT, d, k);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL midrst_status got %h want 0", d); end
        good(8'h45);
        bus_rd(A_DATA, d, k);
        checks++;
        if (d !== 32'h145) begin errors++; $display("FAIL midrst_frame got %h want 00000145", d); end
        bus_rd(A_STAT, d, k);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL midrst_final got %h want 0", d); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_errors();
        test_overflow();
        test_simul();
        test_back_to_back();
        test_flush();
        test_reset_midframe();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
